// File: rtl/pe_credit_arbiter.sv
// rtl/pe_credit_arbiter.sv - credit-gated round-robin packet arbiter onto one output link
module pe_credit_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 20,
  parameter int CREDITS = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               ci,
  output logic [DW-1:0]      dataout,
  output logic               out_valid,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         credits,
  output logic               credit_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, owner, winner, sel;
  logic            win_found, accept, tail, has_credit;
  logic [DW-1:0]   sel_data;
  logic [DW-1:0]   data_arr [N_REQ];

  // Next index after i, wrapping at N_REQ
  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] i);
    if (i == PW'(N_REQ - 1)) return '0;
    return i + PW'(1);
  endfunction

  // base + k modulo N_REQ, k in 0..N_REQ-1
  function automatic logic [PW-1:0] add_mod(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  // Round-robin search: first valid requester at or after rr_ptr
  always_comb begin
    win_found = 1'b0;
    winner    = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req_valid[add_mod(rr_ptr, k)]) begin
        win_found = 1'b1;
        winner    = add_mod(rr_ptr, k);
      end
    end
  end

  // Credit check uses the registered count only; a same-cycle ci does not help
  assign has_credit = (credits != 3'd0);
  assign sel        = (state == LOCKED) ? owner : winner;
  assign sel_data   = data_arr[sel];
  assign tail       = sel_data[DW-1];
  assign accept     = |(req_valid & req_ready);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: lock on a non-tail head flit, unlock on the owner's tail flit
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (state == IDLE && !tail)       state_nxt = LOCKED;
      else if (state == LOCKED && tail) state_nxt = IDLE;
    end
  end

  // Ready outputs: only the winner (IDLE) or the owner (LOCKED), never during reset
  always_comb begin
    req_ready = '0;
    if (!rst && has_credit) begin
      if (state == LOCKED)  req_ready[owner]  = 1'b1;
      else if (win_found)   req_ready[winner] = 1'b1;
    end
  end

  // Owner, grant and round-robin pointer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      owner  <= '0;
      grant  <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        if (tail) begin
          rr_ptr <= inc_mod(winner);
        end else begin
          owner <= winner;
          grant <= N_REQ'(1) << winner;
        end
      end else if (tail) begin
        grant  <= '0;
        rr_ptr <= inc_mod(owner);
      end
    end
  end

  // Registered output flit; dataout holds when nothing was accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dataout   <= '0;
    end else begin
      out_valid <= accept;
      if (accept) dataout <= sel_data;
    end
  end

  // Credit counter with saturating return and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({accept, ci})
        2'b10: credits <= credits - 3'd1;
        2'b01: begin
          if (credits == CREDIT_MAX) credit_err <= 1'b1;
          else                       credits    <= credits + 3'd1;
        end
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_credit_arbiter.sv
// tb/tb_pe_credit_arbiter.sv - directed self-checking bench for pe_credit_arbiter
module tb_pe_credit_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                ci;
  logic [DW-1:0]       dataout;
  logic                out_valid;
  logic [N_REQ-1:0]    grant;
  logic [2:0]          credits;
  logic                credit_err;

  int errors = 0;
  int checks = 0;

  pe_credit_arbiter #(.N_REQ(N_REQ), .DW(DW), .CREDITS(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ci         (ci),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .grant      (grant),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input logic t, input int p);
    logic [31:0] pv;
    pv = p;
    return {t, pv[DW-2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; ci = 1'b0; req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ci = 1'b0; req_valid = '0; req_data = '0;

    // reset with requests pending: nothing may be ready
    req_valid = 4'b1111;
    #1;
    check("rst_ready", req_ready, 0);
    tick(); tick();
    check("rst_credits", credits, 7);
    check("rst_err", credit_err, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_grant", grant, 0);
    check("rst_dout", dataout, 0);
    rst = 1'b0; req_valid = '0;

    // round robin over single-flit packets
    for (int i = 0; i < N_REQ; i++) set_data(i, flit(1'b1, 'h100 + i));
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      check("rr_ready", req_ready, 1 << i);
      tick();
      check("rr_ovalid", out_valid, 1);
      check("rr_dout", dataout, flit(1'b1, 'h100 + i));
      check("rr_grant", grant, 0);
      #1;
    end
    check("rr_credits", credits, 3);
    req_valid = '0;
    #1;
    check("rr_idle_ready", req_ready, 0);
    tick();
    check("rr_idle_ovalid", out_valid, 0);
    check("rr_hold_dout", dataout, flit(1'b1, 'h103));

    // packet lock: req0 3-flit packet with req1 waiting, req0 stalls once mid-packet
    do_reset();
    set_data(1, flit(1'b1, 'h1B0));
    set_data(0, flit(1'b0, 'h1A1));
    req_valid = 4'b0011;
    #1;
    check("lk_ready1", req_ready, 4'b0001);
    tick();
    check("lk_grant1", grant, 4'b0001);
    check("lk_dout1", dataout, flit(1'b0, 'h1A1));
    set_data(0, flit(1'b0, 'h1A2));
    #1;
    check("lk_ready2", req_ready, 4'b0001);
    tick();
    check("lk_grant2", grant, 4'b0001);
    req_valid = 4'b0010;
    #1;
    check("lk_drop_ready", req_ready, 4'b0001);
    tick();
    check("lk_drop_ovalid", out_valid, 0);
    check("lk_drop_grant", grant, 4'b0001);
    check("lk_drop_dout", dataout, flit(1'b0, 'h1A2));
    set_data(0, flit(1'b1, 'h1A3));
    req_valid = 4'b0011;
    #1;
    check("lk_ready3", req_ready, 4'b0001);
    tick();
    check("lk_tail_grant", grant, 0);
    check("lk_tail_dout", dataout, flit(1'b1, 'h1A3));
    req_valid = 4'b0010;
    #1;
    check("lk_next_ready", req_ready, 4'b0010);
    tick();
    check("lk_next_dout", dataout, flit(1'b1, 'h1B0));
    check("lk_credits", credits, 3);

    // credit stall: 8 attempts, 7 accepted; then one ci lets exactly one more through
    do_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      set_data(0, flit(1'b1, 'h200 + k));
      #1;
      check("cs_ready", req_ready, 4'b0001);
      tick();
      check("cs_ovalid", out_valid, 1);
      check("cs_dout", dataout, flit(1'b1, 'h200 + k));
    end
    set_data(0, flit(1'b1, 'h207));
    #1;
    check("cs_credits0", credits, 0);
    check("cs_ready0", req_ready, 0);
    tick();
    check("cs_stall_ovalid", out_valid, 0);
    ci = 1'b1;
    #1;
    check("cs_ci_ready", req_ready, 0);
    tick();
    ci = 1'b0;
    check("cs_ci_credits", credits, 1);
    check("cs_ci_ovalid", out_valid, 0);
    #1;
    check("cs_ready1", req_ready, 4'b0001);
    tick();
    check("cs_last_ovalid", out_valid, 1);
    check("cs_last_dout", dataout, flit(1'b1, 'h207));
    check("cs_last_credits", credits, 0);
    #1;
    check("cs_after_ready", req_ready, 0);

    // ci together with continuous acceptance keeps credits at 7
    do_reset();
    req_valid = 4'b0001;
    ci = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_data(0, flit(1'b1, 'h300 + k));
      tick();
      check("sim_ovalid", out_valid, 1);
      check("sim_credits", credits, 7);
    end

    // overflow: ci at full credits with no request, flag is sticky until reset
    req_valid = '0;
    tick();
    ci = 1'b0;
    check("ov_credits", credits, 7);
    check("ov_err", credit_err, 1);
    req_valid = 4'b0001;
    tick(); tick();
    req_valid = '0;
    check("ov_traffic_credits", credits, 5);
    check("ov_sticky", credit_err, 1);
    do_reset();
    check("ov_cleared", credit_err, 0);

    // mid-packet reset: move rr_ptr away from 0, open a req2 packet, reset after flit 2
    set_data(1, flit(1'b1, 'h401));
    req_valid = 4'b0010;
    #1;
    check("mr_ready_r1", req_ready, 4'b0010);
    tick();
    set_data(2, flit(1'b0, 'h4C1));
    req_valid = 4'b0100;
    #1;
    check("mr_ready_r2", req_ready, 4'b0100);
    tick();
    check("mr_grant", grant, 4'b0100);
    set_data(2, flit(1'b0, 'h4C2));
    tick();
    check("mr_credits_pre", credits, 4);
    rst = 1'b1;
    ci = 1'b1;
    set_data(0, flit(1'b1, 'h4D0));
    set_data(2, flit(1'b0, 'h4C3));
    req_valid = 4'b0101;
    #1;
    check("mr_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    ci = 1'b0;
    check("mr_grant0", grant, 0);
    check("mr_ovalid0", out_valid, 0);
    check("mr_credits7", credits, 7);
    check("mr_err0", credit_err, 0);
    #1;
    check("mr_req0_wins", req_ready, 4'b0001);
    tick();
    check("mr_dout", dataout, flit(1'b1, 'h4D0));
    check("mr_grant_after", grant, 0);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
